// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline stage register.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b01,
      FULL  = 2'b10
   } skid_state_t;

endpackage

// File: rtl/flopenr.sv
// WIDTH-bit flop with load enable and synchronous active-low reset to RESET_VALUE.
module flopenr #(
   parameter int                 WIDTH       = 32,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk_in) begin
      if (!rst_in)
         q <= RESET_VALUE;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
//
//   state | meaning
//   ------+-------------------------------------------------
//   EMPTY | nothing held, out_valid=0
//   BUSY  | one entry in main, accepting and presenting
//   FULL  | main and skid both hold entries, in_ready=0
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   skid_state_t      state_q, state_d;
   logic             in_fire, out_fire;
   logic             main_en, skid_en, main_from_skid;
   logic             main_load, skid_load;
   logic [WIDTH-1:0] main_d, skid_d, main_q, skid_q;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clk_in) begin
      if (!rst_in)
         state_q <= EMPTY;
      else if (flush)
         state_q <= EMPTY;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (in_fire) state_d = BUSY;
         BUSY: begin
            if (in_fire && !out_ready)
               state_d = FULL;
            else if (!in_fire && out_fire)
               state_d = EMPTY;
         end
         FULL:    if (out_fire) state_d = BUSY;
         default: state_d = EMPTY;
      endcase
   end

   // Outputs decode only registered state, so in_ready never sees out_ready.
   always_comb begin
      out_valid = 1'b0;
      in_ready  = 1'b1;
      count     = 2'd0;
      case (state_q)
         BUSY: begin
            out_valid = 1'b1;
            count     = 2'd1;
         end
         FULL: begin
            out_valid = 1'b1;
            in_ready  = 1'b0;
            count     = 2'd2;
         end
         default: ;
      endcase
   end

   always_comb begin
      main_en        = 1'b0;
      skid_en        = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         EMPTY: main_en = in_fire;
         BUSY: begin
            main_en = in_fire && out_fire;
            skid_en = in_fire && !out_ready;
         end
         FULL: begin
            main_en        = out_fire;
            main_from_skid = 1'b1;
         end
         default: ;
      endcase
   end

   // Flush reuses the load path to write the bubble value into both registers.
   assign main_load = main_en || flush;
   assign skid_load = skid_en || flush;
   assign main_d    = flush ? RESET_VALUE : (main_from_skid ? skid_q : in_data);
   assign skid_d    = flush ? RESET_VALUE : in_data;

   flopenr #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .en     (main_load),
      .d      (main_d),
      .q      (main_q)
   );

   flopenr #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .en     (skid_load),
      .d      (skid_d),
      .q      (skid_q)
   );

   assign out_data = main_q;

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the single-bit resettable flop: a WIDTH-bit pipeline stage register with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
- It is used between MIPS pipeline stages (IF/ID, ID/EX, ...) so that back-pressure can stall the upstream stage and hazard logic can inject bubbles.
- Full throughput, with no combinational path from out_ready to in_ready.

Parameters:
- WIDTH, 32: data width in bits.
- RESET_VALUE, '0: value loaded into the data registers on reset and on flush (the bubble, e.g. a NOP encoding).

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset, synchronous and active-low.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  this stage can accept data.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  head entry.
- count  output  2  number of entries held (0..2).

Behaviour:
- Handshakes:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready.
- Storage: main register (drives out_data) and skid register. State is one of EMPTY (count 0), BUSY (1), FULL (2).
- Derived outputs, all purely from registered state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - count = 0, 1 or 2 for EMPTY, BUSY, FULL.
- Reset (rst_in == 0 at a rising edge):
  - state goes to EMPTY, main and skid load RESET_VALUE.
  - After reset: out_valid=0, in_ready=1, count=0, out_data=RESET_VALUE.
  - Reset overrides flush and any in-flight handshake, including mid-stall in FULL.
- Flush (rst_in=1, flush=1): same effect as reset, one cycle.
  - in_fire and out_fire in that cycle are ignored; the input is discarded.
  - The upstream must treat its offer as dropped.
- Transitions, when not in reset or flush:
  - EMPTY: in_fire moves to BUSY with main <= in_data. Otherwise hold.
  - BUSY, in_fire && out_fire: stay in BUSY, main <= in_data.
  - BUSY, in_fire && !out_ready: go to FULL, skid <= in_data, main holds.
  - BUSY, !in_fire && out_fire: go to EMPTY. main keeps its last value and out_data is not cleared.
  - BUSY, otherwise: hold.
  - FULL: in_ready=0. out_fire moves to BUSY with main <= skid. Otherwise hold.
- Latency: data accepted in cycle N appears on out_data with out_valid in cycle N+1 when the stage was EMPTY or draining.
- Throughput: 1 word/cycle at steady state.
- Ordering: strict FIFO order. No word is lost or duplicated except on flush or reset.
- Stability: while out_valid && !out_ready, out_data and out_valid do not change.
- Boundary: in_valid while FULL is a non-transfer. in_data is ignored and the upstream holds its value.
- X-safety: out_data never goes X after the first reset.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] skid_state_t {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10}.
  - No other shared constants.
- One natural sub-module: flopenr. It is a WIDTH-parametrised flop with enable and synchronous active-low reset to RESET_VALUE. It is instantiated twice (main, skid).
- The flush mux and next-state logic stay in pipe_skid_reg.

Test Plan:
- Reset: hold rst_in=0 for 2 cycles with in_valid=1, in_data=32'hDEADBEEF, then release. Required: out_valid=0, in_ready=1, count=0, out_data=0 until the first accepted word.
- Streaming: out_ready=1, push 1,2,3,4 on consecutive cycles. Required: out_data shows 1,2,3,4 on cycles N+1..N+4; in_ready stays 1; count stays 1.
- Back-pressure:
  - Push 10,11,12 with out_ready=0. Required: 10 and 11 accepted, count=2, in_ready=0, 12 held upstream, out_data=10 stable.
  - Then set out_ready=1. Required: 10, 11, 12 emerge in order with no gap after the first.
- Flush in FULL: with entries 20,21 held, assert flush while in_valid=1, in_data=22. Required next cycle: count=0, out_valid=0, in_ready=1, out_data=RESET_VALUE, and 22 never emerges.
- Reset mid-stall: FULL with 30,31, drive rst_in=0 for 1 cycle while out_ready=1. Required: no output transfer, state EMPTY, out_data=RESET_VALUE.
- Random: 10k cycles of random in_valid, out_ready and flush checked against a queue scoreboard. Required: order preserved, no loss between flushes, in_ready never depends combinationally on out_ready.
